ball_engine: RTL

Parametrised successor to the single-ball controller. It moves one ball inside a configurable rectangular field and bounces it off the field walls and off up to NUM_PLAYERS circular players. It detects entry into any of six goal hoops (three top, three bottom), keeps per-side goal counters, and re-serves the ball after each goal. It sits between the player-position controllers and the VGA renderer, and drives the ball centre coordinates the renderer draws.

---
 rtl/ball_engine.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ball_engine.sv
// Ball movement engine: serves, moves and bounces one ball off walls and players,
// detects entry into six goal hoops and keeps saturating per-row goal counters.
module ball_engine #(
    parameter int X_MIN         = 150,
    parameter int X_MAX         = 660,
    parameter int Y_MIN         = 36,
    parameter int Y_MAX         = 510,
    parameter int BALL_RADIUS   = 8,
    parameter int PLAYER_RADIUS = 35,
    parameter int GOAL_RADIUS   = 25,
    parameter int GOAL_X0       = 300,
    parameter int GOAL_X1       = 400,
    parameter int GOAL_X2       = 500,
    parameter int GOAL_Y_TOP    = 100,
    parameter int GOAL_Y_BOTTOM = 450,
    parameter int START_X       = 463,
    parameter int START_Y       = 275,
    parameter int NUM_PLAYERS   = 4,
    parameter int TICK_DIV      = 200000,
    parameter int STEP          = 1,
    parameter int SERVE_TICKS   = 60,
    parameter int SCORE_W       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      game_on,
    input  logic                      game_over,
    input  logic [10*NUM_PLAYERS-1:0] player_x,
    input  logic [10*NUM_PLAYERS-1:0] player_y,
    input  logic [NUM_PLAYERS-1:0]    player_en,
    output logic [9:0]                x_position,
    output logic [9:0]                y_position,
    output logic                      ball_live,
    output logic                      goal_top,
    output logic                      goal_bottom,
    output logic [SCORE_W-1:0]        hits_top,
    output logic [SCORE_W-1:0]        hits_bottom
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] MOVE  = 2'd2;

    localparam int TICK_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SERVE_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;

    localparam logic [9:0] X_LO = 10'(X_MIN + BALL_RADIUS);
    localparam logic [9:0] X_HI = 10'(X_MAX - BALL_RADIUS);
    localparam logic [9:0] Y_LO = 10'(Y_MIN + BALL_RADIUS);
    localparam logic [9:0] Y_HI = 10'(Y_MAX - BALL_RADIUS);

    localparam logic [22:0] GOAL_R2   = 23'((GOAL_RADIUS - BALL_RADIUS) * (GOAL_RADIUS - BALL_RADIUS));
    localparam logic [22:0] PLAYER_R2 = 23'((PLAYER_RADIUS + BALL_RADIUS) * (PLAYER_RADIUS + BALL_RADIUS));

    localparam logic [9:0] GX0 = 10'(GOAL_X0);
    localparam logic [9:0] GX1 = 10'(GOAL_X1);
    localparam logic [9:0] GX2 = 10'(GOAL_X2);
    localparam logic [9:0] GYT = 10'(GOAL_Y_TOP);
    localparam logic [9:0] GYB = 10'(GOAL_Y_BOTTOM);

    function automatic logic signed [10:0] diff(input logic [9:0] a, input logic [9:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic [22:0] sq(input logic signed [10:0] d);
        logic [10:0] m;
        m = d[10] ? 11'(-d) : 11'(d);
        return {12'd0, m} * {12'd0, m};
    endfunction

    function automatic logic [22:0] dist2(input logic [9:0] ax, input logic [9:0] ay,
                                          input logic [9:0] bx, input logic [9:0] by);
        return sq(diff(ax, bx)) + sq(diff(ay, by));
    endfunction

    // One step along an axis, clamped to the legal centre range of the ball.
    function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic up,
                                              input logic [9:0] lo, input logic [9:0] hi);
        logic signed [12:0] s;
        s = up ? $signed({3'b0, pos}) + $signed(13'(STEP))
               : $signed({3'b0, pos}) - $signed(13'(STEP));
        if (s < $signed({3'b0, lo}))
            return lo;
        else if (s > $signed({3'b0, hi}))
            return hi;
        else
            return s[9:0];
    endfunction

    logic [1:0]         state, state_n;
    logic [TICK_W-1:0]  tick_cnt;
    logic [SERVE_W-1:0] serve_cnt, serve_n;
    logic               dir_x, dir_y, dir_x_n, dir_y_n;
    logic [9:0]         x_n, y_n;
    logic               goal_top_n, goal_bottom_n;
    logic [SCORE_W-1:0] hits_top_n, hits_bottom_n;
    logic               tick;

    logic               top_hit, bottom_hit;
    logic               player_hit;
    logic signed [10:0] pdx, pdy;
    logic               move_dx, move_dy;
    logic [9:0]         move_x, move_y;

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    assign top_hit = (dist2(x_position, y_position, GX0, GYT) < GOAL_R2)
                  || (dist2(x_position, y_position, GX1, GYT) < GOAL_R2)
                  || (dist2(x_position, y_position, GX2, GYT) < GOAL_R2);
    assign bottom_hit = (dist2(x_position, y_position, GX0, GYB) < GOAL_R2)
                     || (dist2(x_position, y_position, GX1, GYB) < GOAL_R2)
                     || (dist2(x_position, y_position, GX2, GYB) < GOAL_R2);

    // Lowest-index enabled player in contact decides the deflection.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        player_hit = 1'b0;
        pdx        = '0;
        pdy        = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!player_hit && player_en[i]
                && dist2(x_position, y_position, player_x[10*i +: 10], player_y[10*i +: 10]) < PLAYER_R2) begin
                player_hit = 1'b1;
                pdx        = diff(x_position, player_x[10*i +: 10]);
                pdy        = diff(y_position, player_y[10*i +: 10]);
            end
        end
    end

    always_comb begin
        move_dx = dir_x;
        if (x_position <= X_LO)
            move_dx = 1'b1;
        else if (x_position >= X_HI)
            move_dx = 1'b0;
        else if (player_hit && pdx != 11'sd0)
            move_dx = !pdx[10];

        move_dy = dir_y;
        if (y_position <= Y_LO)
            move_dy = 1'b1;
        else if (y_position >= Y_HI)
            move_dy = 1'b0;
        else if (player_hit && pdy != 11'sd0)
            move_dy = !pdy[10];

        move_x = step_clamp(x_position, move_dx, X_LO, X_HI);
        move_y = step_clamp(y_position, move_dy, Y_LO, Y_HI);
    end

    always_comb begin
        state_n       = state;
        serve_n       = serve_cnt;
        x_n           = x_position;
        y_n           = y_position;
        dir_x_n       = dir_x;
        dir_y_n       = dir_y;
        goal_top_n    = 1'b0;
        goal_bottom_n = 1'b0;
        hits_top_n    = hits_top;
        hits_bottom_n = hits_bottom;

        if (game_over) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (game_on) begin
                        state_n = SERVE;
                        serve_n = '0;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        serve_n = serve_cnt + 1'b1;
                        if (32'(serve_cnt) + 1 >= SERVE_TICKS)
                            state_n = MOVE;
                    end
                end
                MOVE: begin
                    if (tick) begin
                        if (top_hit || bottom_hit) begin
                            // A goal re-serves from the start point toward the other row.
                            goal_top_n    = top_hit;
                            goal_bottom_n = !top_hit;
                            if (top_hit && hits_top != '1)
                                hits_top_n = hits_top + 1'b1;
                            if (!top_hit && hits_bottom != '1)
                                hits_bottom_n = hits_bottom + 1'b1;
                            x_n     = 10'(START_X);
                            y_n     = 10'(START_Y);
                            dir_x_n = 1'b1;
                            dir_y_n = top_hit;
                            state_n = SERVE;
                            serve_n = '0;
                        end else begin
                            dir_x_n = move_dx;
                            dir_y_n = move_dy;
                            x_n     = move_x;
                            y_n     = move_y;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            serve_cnt   <= '0;
            x_position  <= 10'(START_X);
            y_position  <= 10'(START_Y);
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            ball_live   <= 1'b0;
            goal_top    <= 1'b0;
            goal_bottom <= 1'b0;
            hits_top    <= '0;
            hits_bottom <= '0;
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            state       <= state_n;
            serve_cnt   <= serve_n;
            x_position  <= x_n;
            y_position  <= y_n;
            dir_x       <= dir_x_n;
            dir_y       <= dir_y_n;
            ball_live   <= (state_n == MOVE);
            goal_top    <= goal_top_n;
            goal_bottom <= goal_bottom_n;
            hits_top    <= hits_top_n;
            hits_bottom <= hits_bottom_n;
        end
    end

endmodule
